ps2_kbd_ctrl: RTL and testbench

//  Sequences a PS/2 scan-code receiver: pops bytes with the receiver's ready/nextdata_n handshake.

---
 rtl/ps2_pkg.sv | 24 ++
 rtl/ps2_kbd_ctrl_if.sv | 26 ++
 rtl/ps2_evt_fifo.sv | 61 ++++++
 rtl/ps2_kbd_ctrl.sv | 153 +++++++++++++++
 tb/tb_ps2_kbd_ctrl.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard controller slice:
// prefix bytes, the queued key-event record and the byte-sequencer states.
package ps2_pkg;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ps2_evt_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACK,
        S_GAP
    } ps2_state_t;

    function automatic logic is_prefix(input logic [7:0] b);
        return (b == PS2_EXT) || (b == PS2_BRK);
    endfunction

endpackage

// File: rtl/ps2_kbd_ctrl_if.sv
// Byte-side (receiver) and event-side (consumer) handshake bundle of the
// keyboard controller; master is the controller, slave is its environment.
interface ps2_kbd_ctrl_if;

    logic       rx_ready;
    logic [7:0] rx_data;
    logic       rx_overflow;
    logic       rx_nextdata_n;

    logic       ev_valid;
    logic       ev_ready;
    logic [7:0] ev_code;
    logic       ev_ext;
    logic       ev_break;

    modport master (
        input  rx_ready, rx_data, rx_overflow, ev_ready,
        output rx_nextdata_n, ev_valid, ev_code, ev_ext, ev_break
    );

    modport slave (
        output rx_ready, rx_data, rx_overflow, ev_ready,
        input  rx_nextdata_n, ev_valid, ev_code, ev_ext, ev_break
    );

endinterface

// File: rtl/ps2_evt_fifo.sv
// Synchronous FIFO of key events. Pointers carry one extra wrap bit; when
// empty the head output keeps showing the last entry that was popped.
module ps2_evt_fifo
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic     clock,
    input  logic     reset,
    input  logic     push,
    input  ps2_evt_t push_data,
    input  logic     pop,
    output ps2_evt_t head,
    output logic     full,
    output logic     empty
);

    localparam int AW = $clog2(FIFO_DEPTH);

    ps2_evt_t      mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    ps2_evt_t      last_head;
    logic          do_pop;
    logic          do_push;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? last_head : mem[rd_ptr[AW-1:0]];

    // NOTE: storage has no reset; it is never observed before being written,
    // and leaving it unreset lets it map onto plain RAM/flop arrays.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            last_head <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr    <= rd_ptr + 1'b1;
                last_head <= mem[rd_ptr[AW-1:0]];
            end
        end
    end

endmodule

// File: rtl/ps2_kbd_ctrl.sv
// PS/2 scan-code sequencer: pops receiver bytes, folds E0/F0 prefixes into
// key events, queues them and tracks held-key state. Define
// PS2_TYPEMATIC_FILTER_EN to suppress typematic repeats of the held key.
module ps2_kbd_ctrl
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    ps2_kbd_ctrl_if.master        ps2,
    output logic [7:0]            press_count,
    output logic                  key_down,
    output logic [8:0]            held_code,
    input  logic                  err_clr,
    output logic                  err_ovf,
    output logic                  err_drop
);

    ps2_state_t state;
    logic [7:0] byte_q;
    logic       nextdata_n;
    logic       ext_pend;
    logic       brk_pend;

    logic       decoding;
    logic       is_repeat;
    logic       ev_fire;
    logic       ev_pop;
    logic       ev_drop;
    logic [8:0] key;
    ps2_evt_t   new_evt;
    ps2_evt_t   head_evt;
    logic       fifo_full;
    logic       fifo_empty;

`ifdef PS2_TYPEMATIC_FILTER_EN
    assign is_repeat = !brk_pend && key_down && (key == held_code);
`else
    assign is_repeat = 1'b0;
`endif

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        decoding = 1'b0;
        key      = '0;
        new_evt  = '0;
        ev_fire  = 1'b0;
        decoding = (state == S_ACK);
        key      = {ext_pend, byte_q};
        new_evt  = '{ext: ext_pend, brk: brk_pend, code: byte_q};
        ev_fire  = decoding && !is_prefix(byte_q) && !is_repeat;
    end

    assign ev_pop  = !fifo_empty && ps2.ev_ready;
    assign ev_drop = ev_fire && fifo_full && !ev_pop;

    // Byte sequencer: latch head byte, strobe pop for one cycle, then a gap
    // cycle so the receiver can present its next byte.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            byte_q     <= '0;
            nextdata_n <= 1'b1;
            ext_pend   <= 1'b0;
            brk_pend   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (ps2.rx_ready) begin
                        byte_q     <= ps2.rx_data;
                        nextdata_n <= 1'b0;
                        state      <= S_ACK;
                    end
                end
                S_ACK: begin
                    nextdata_n <= 1'b1;
                    state      <= S_GAP;
                    if (byte_q == PS2_EXT) begin
                        ext_pend <= 1'b1;
                    end else if (byte_q == PS2_BRK) begin
                        brk_pend <= 1'b1;
                    end else begin
                        ext_pend <= 1'b0;
                        brk_pend <= 1'b0;
                    end
                end
                S_GAP: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Held-key tracking follows every decoded event, even one the FIFO drops.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            press_count <= '0;
            key_down    <= 1'b0;
            held_code   <= '0;
        end else if (ev_fire) begin
            if (!brk_pend) begin
                held_code   <= key;
                key_down    <= 1'b1;
                press_count <= press_count + 1'b1;
            end else if (key == held_code) begin
                key_down <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            err_ovf  <= 1'b0;
            err_drop <= 1'b0;
        end else begin
            if (ps2.rx_overflow) begin
                err_ovf <= 1'b1;
            end else if (err_clr) begin
                err_ovf <= 1'b0;
            end
            if (ev_drop) begin
                err_drop <= 1'b1;
            end else if (err_clr) begin
                err_drop <= 1'b0;
            end
        end
    end

    ps2_evt_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (ev_fire),
        .push_data (new_evt),
        .pop       (ev_pop),
        .head      (head_evt),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign ps2.rx_nextdata_n = nextdata_n;
    assign ps2.ev_valid      = !fifo_empty;
    assign ps2.ev_code       = head_evt.code;
    assign ps2.ev_ext        = head_evt.ext;
    assign ps2.ev_break      = head_evt.brk;

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Self-checking bench for ps2_kbd_ctrl: a byte-queue receiver model, a
// reference decoder feeding an event scoreboard, and directed scenarios.
module tb_ps2_kbd_ctrl;
    import ps2_pkg::*;

    localparam int DEPTH = 8;
`ifdef PS2_TYPEMATIC_FILTER_EN
    localparam bit FILT = 1'b1;
`else
    localparam bit FILT = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] press_count;
    logic       key_down;
    logic [8:0] held_code;
    logic       err_clr = 1'b0;
    logic       err_ovf;
    logic       err_drop;

    always #5 clock = ~clock;

    ps2_kbd_ctrl_if ifc ();

    ps2_kbd_ctrl #(.FIFO_DEPTH(DEPTH)) dut (
        .clock       (clock),
        .reset       (reset),
        .ps2         (ifc),
        .press_count (press_count),
        .key_down    (key_down),
        .held_code   (held_code),
        .err_clr     (err_clr),
        .err_ovf     (err_ovf),
        .err_drop    (err_drop)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Receiver byte queue and expected-event scoreboard.
    logic [7:0] rxq [$];
    logic [9:0] exp_q [$];

    // Reference decoder state.
    bit         m_ext, m_brk, m_kd;
    logic [8:0] m_held;
    logic [7:0] m_press;
    int         pulses = 0;
    int         long_pulses = 0;
    int         ev_seen = 0;
    bit         prev_low = 1'b0;
    int         rdy_mode = 1;   // 0: never ready, 1: always ready, 2: ready only in pop cycles

    function automatic void model_byte(input logic [7:0] b);
        logic [8:0] k;
        bit         rep;
        if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else begin
            k   = {m_ext, b};
            rep = FILT && !m_brk && m_kd && (k == m_held);
            if (!rep) begin
                if (exp_q.size() < DEPTH) exp_q.push_back({m_ext, m_brk, b});
                if (!m_brk) begin
                    m_held  = k;
                    m_kd    = 1'b1;
                    m_press = m_press + 8'd1;
                end else if (k == m_held) begin
                    m_kd = 1'b0;
                end
            end
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endfunction

    always @(negedge clock) begin
        if (!reset) begin
            m_ext = 0; m_brk = 0; m_kd = 0; m_held = '0; m_press = '0;
            exp_q.delete();
            prev_low = 1'b0;
        end else begin
            ifc.ev_ready = (rdy_mode == 1) || (rdy_mode == 2 && ifc.rx_nextdata_n == 1'b0);
            if (ifc.rx_nextdata_n == 1'b0) begin
                pulses++;
                if (prev_low) long_pulses++;
            end
            prev_low = (ifc.rx_nextdata_n == 1'b0);
            if (ifc.ev_valid && ifc.ev_ready) begin
                ev_seen++;
                if (exp_q.size() == 0)
                    check("ev_unexpected", 0, 1);
                else
                    check("ev", {ifc.ev_ext, ifc.ev_break, ifc.ev_code}, exp_q.pop_front());
            end
            if (ifc.rx_nextdata_n == 1'b0 && rxq.size() != 0) begin
                model_byte(rxq.pop_front());
                ifc.rx_ready = (rxq.size() != 0);
                if (rxq.size() != 0) ifc.rx_data = rxq[0];
            end
        end
    end

    task automatic send(input logic [7:0] b);
        @(posedge clock);
        #1;
        rxq.push_back(b);
        ifc.rx_ready = 1'b1;
        ifc.rx_data  = rxq[0];
    endtask

    task automatic drain();
        int budget = 3000;
        while ((rxq.size() != 0 || (rdy_mode == 1 && exp_q.size() != 0)) && budget > 0) begin
            @(negedge clock);
            budget--;
        end
        check("drain_budget", (budget == 0), 0);
        repeat (4) @(negedge clock);
    endtask

    task automatic check_reset_values(input string pfx);
        check({pfx, "_nextdata_n"}, ifc.rx_nextdata_n, 1);
        check({pfx, "_ev_valid"},   ifc.ev_valid, 0);
        check({pfx, "_ev_head"},    {ifc.ev_ext, ifc.ev_break, ifc.ev_code}, 0);
        check({pfx, "_press"},      press_count, 0);
        check({pfx, "_key_down"},   key_down, 0);
        check({pfx, "_held"},       held_code, 0);
        check({pfx, "_errs"},       {err_ovf, err_drop}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0, e0, n, budget;
        ifc.rx_ready    = 1'b0;
        ifc.rx_data     = 8'h00;
        ifc.rx_overflow = 1'b0;
        ifc.ev_ready    = 1'b0;

        repeat (3) @(posedge clock);
        #1;
        check_reset_values("rst");
        reset = 1'b1;

        // T1: make then break of 1C.
        p0 = pulses;
        send(8'h1C);
        drain();
        check("t1_key_down_make", key_down, 1);
        check("t1_held", held_code, 9'h01C);
        send(8'hF0); send(8'h1C);
        drain();
        check("t1_key_down_break", key_down, 0);
        check("t1_press", press_count, 1);
        check("t1_pulses", pulses - p0, 3);
        check("t1_pulse_width", long_pulses, 0);

        // T2: extended make and extended break, prefixes in mixed order.
        send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
        drain();
        check("t2_held", held_code, 9'h175);
        check("t2_key_down", key_down, 0);
        check("t2_press", press_count, 2);

        // T3: typematic repeats.
        e0 = ev_seen;
        send(8'h1B); send(8'h1B); send(8'h1B); send(8'hF0); send(8'h1B);
        drain();
        check("t3_events", ev_seen - e0, FILT ? 2 : 4);
        check("t3_press", press_count, FILT ? 3 : 5);

        // T4: overfill the FIFO with the consumer stalled.
        rdy_mode = 0;
        for (int i = 0; i < 9; i++) send(8'h21 + 8'(i));
        drain();
        check("t4_valid", ifc.ev_valid, 1);
        check("t4_head", {ifc.ev_ext, ifc.ev_break, ifc.ev_code}, 10'h021);
        check("t4_drop", err_drop, 1);
        check("t4_press", press_count, FILT ? 12 : 14);
        rdy_mode = 2;
        send(8'h2A);
        drain();
        rdy_mode = 1;
        drain();
        check("t4_empty", ifc.ev_valid, 0);
        check("t4_hold_last", {ifc.ev_ext, ifc.ev_break, ifc.ev_code}, 10'h02A);
        check("t4_press_after", press_count, FILT ? 13 : 15);

        // T5: press counter wrap, then sticky error handling.
        n = 255 - (FILT ? 13 : 15);
        for (int i = 0; i < n; i++) send(i[0] ? 8'h16 : 8'h15);
        drain();
        check("t5_press_ff", press_count, 8'hFF);
        send(8'h33);
        drain();
        check("t5_press_wrap", press_count, 8'h00);
        @(posedge clock); #1 ifc.rx_overflow = 1'b1;
        @(posedge clock); #1 ifc.rx_overflow = 1'b0;
        check("t5_ovf_set", err_ovf, 1);
        check("t5_drop_sticky", err_drop, 1);
        err_clr = 1'b1; ifc.rx_overflow = 1'b1;
        @(posedge clock); #1;
        check("t5_set_wins", err_ovf, 1);
        check("t5_drop_clr", err_drop, 0);
        ifc.rx_overflow = 1'b0;
        @(posedge clock); #1;
        err_clr = 1'b0;
        check("t5_ovf_clr", err_ovf, 0);

        // T6: reset after an F0 prefix has been popped.
        send(8'hF0);
        budget = 100;
        do begin
            @(negedge clock);
            budget--;
        end while (ifc.rx_nextdata_n != 1'b0 && budget > 0);
        check("t6_pop_budget", (budget == 0), 0);
        @(posedge clock); #1 reset = 1'b0;
        @(posedge clock); #1;
        check_reset_values("t6_rst");
        check("t6_sb_flushed", exp_q.size(), 0);
        @(posedge clock); #1 reset = 1'b1;
        e0 = ev_seen;
        send(8'h1C);
        drain();
        check("t6_events", ev_seen - e0, 1);
        check("t6_press", press_count, 1);
        check("t6_held", held_code, 9'h01C);
        check("t6_key_down", key_down, 1);
        check("sb_left", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
